// File: rtl/mcu_link_pkg.sv
// Symbol table, lock FSM encodings and upstream lane layout shared by both
// ends of the ROCSTAR <-> MCU cable.
package mcu_link_pkg;

    localparam logic [3:0] SYM_IDLE0 = 4'b0111;
    localparam logic [3:0] SYM_IDLE1 = 4'b1011;
    localparam logic [3:0] SYM_IDLE2 = 4'b1101;
    localparam logic [3:0] SYM_IDLE3 = 4'b1110;
    localparam logic [3:0] SYM_NCOIN = 4'b1001;
    localparam logic [3:0] SYM_PCOIN = 4'b0011;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // Position of the "single" flag on the 8-bit upstream lane.
    localparam int TX_SINGLE_BIT = 7;

    // Next idle in the rotation; IDLE3 wraps to IDLE0.
    function automatic logic [3:0] idle_succ(input logic [3:0] sym);
        case (sym)
            SYM_IDLE0: return SYM_IDLE1;
            SYM_IDLE1: return SYM_IDLE2;
            SYM_IDLE2: return SYM_IDLE3;
            default:   return SYM_IDLE0;
        endcase
    endfunction

endpackage

// File: rtl/rocstar_mcu_link_if.sv
// Trigger / cable / status bundle of one ROCSTAR <-> MCU link endpoint.
interface rocstar_mcu_link_if;
    logic        trig;
    logic [6:0]  trig_toff;
    logic [7:0]  tx_out;
    logic [3:0]  rx_in;
    logic        locked;
    logic        accept;
    logic        reject;
    logic        timeout;
    logic        orphan;
    logic        drop;
    logic        code_err;
    logic [15:0] err_cnt;

    modport master (
        output trig, trig_toff, rx_in,
        input  tx_out, locked, accept, reject, timeout, orphan, drop,
               code_err, err_cnt
    );

    modport slave (
        input  trig, trig_toff, rx_in,
        output tx_out, locked, accept, reject, timeout, orphan, drop,
               code_err, err_cnt
    );
endinterface

// File: rtl/mcu_sym_checker.sv
// Classifies the registered downstream symbol and checks it against the
// legal successor of the previous symbol.
module mcu_sym_checker
    import mcu_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rx_q,
    output logic       legal,
    output logic       is_idle,
    output logic       is_pcoin,
    output logic       is_ncoin
);

    logic [3:0] prev_sym;
    logic       prev_vld;
    logic       prev_code;
    logic       is_code;

    // Decode the current symbol and judge it against its predecessor.
    always_comb begin
        is_idle   = (rx_q == SYM_IDLE0) || (rx_q == SYM_IDLE1) ||
                    (rx_q == SYM_IDLE2) || (rx_q == SYM_IDLE3);
        is_pcoin  = (rx_q == SYM_PCOIN);
        is_ncoin  = (rx_q == SYM_NCOIN);
        is_code   = is_pcoin | is_ncoin;
        prev_code = (prev_sym == SYM_PCOIN) || (prev_sym == SYM_NCOIN);
        legal     = 1'b0;
        if (is_idle || is_code) begin
            if (!prev_vld)
                legal = 1'b1;
            else if (prev_code)
                legal = (rx_q == SYM_IDLE0);
            else
                legal = is_code || (rx_q == idle_succ(prev_sym));
        end
    end

    // Track the previous symbol; any idle resyncs the checker after an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sym <= SYM_IDLE0;
            prev_vld <= 1'b0;
        end else if (legal || is_idle) begin
            prev_sym <= rx_q;
            prev_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/rocstar_mcu_link.sv
// ROCSTAR-side endpoint: trigger transmit with holdoff, downstream lock FSM
// and age-indexed matching of PCOIN/NCOIN replies to outstanding triggers.
module rocstar_mcu_link
    import mcu_link_pkg::*;
#(
    parameter int RESP_LAT = 8,
    parameter int WIN      = 1,
    parameter int LOCK_N   = 16,
    parameter int UNLOCK_N = 4,
    parameter int HOLDOFF  = 2
) (
    input  logic clk,
    input  logic rst,
    rocstar_mcu_link_if.slave bus
);

    localparam int PEND_W = RESP_LAT + WIN + 1;
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam int BAD_W  = $clog2(UNLOCK_N + 1);
    localparam int HO_W   = $clog2(HOLDOFF + 2);

    logic [3:0]        rx_q;
    logic              legal, is_idle, is_pcoin, is_ncoin;
    lock_state_t       state, state_nxt;
    logic [GOOD_W-1:0] good_cnt, good_nxt;
    logic [BAD_W-1:0]  bad_cnt, bad_nxt;
    logic              code_err_nxt, unlock_clr;
    logic [HO_W-1:0]   holdoff_cnt;
    logic [PEND_W-1:0] pend, clr_vec, pend_aged;
    logic              code_lk, hit, trig_ok, expire;
    logic [7:0]        tx_nxt;
    logic [7:0]        tx_r;
    logic              accept_r, reject_r, timeout_r, orphan_r, drop_r, code_err_r;
    logic [15:0]       err_cnt_r;

    mcu_sym_checker u_checker (
        .clk      (clk),
        .rst      (rst),
        .rx_q     (rx_q),
        .legal    (legal),
        .is_idle  (is_idle),
        .is_pcoin (is_pcoin),
        .is_ncoin (is_ncoin)
    );

    // Lock FSM next state: acquire on idles, count good/bad symbols.
    always_comb begin
        state_nxt    = state;
        good_nxt     = good_cnt;
        bad_nxt      = bad_cnt;
        code_err_nxt = 1'b0;
        unlock_clr   = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (is_idle) begin
                    state_nxt = ST_LOCKING;
                    good_nxt  = GOOD_W'(1);
                end
            end
            ST_LOCKING: begin
                if (!legal) begin
                    state_nxt = ST_UNLOCKED;
                    good_nxt  = '0;
                end else if (good_cnt == GOOD_W'(LOCK_N - 1)) begin
                    state_nxt = ST_LOCKED;
                    good_nxt  = '0;
                end else begin
                    good_nxt = good_cnt + GOOD_W'(1);
                end
            end
            ST_LOCKED: begin
                if (legal) begin
                    bad_nxt = '0;
                end else begin
                    code_err_nxt = 1'b1;
                    if (bad_cnt == BAD_W'(UNLOCK_N - 1)) begin
                        state_nxt  = ST_UNLOCKED;
                        bad_nxt    = '0;
                        unlock_clr = 1'b1;
                    end else begin
                        bad_nxt = bad_cnt + BAD_W'(1);
                    end
                end
            end
            default: state_nxt = ST_UNLOCKED;
        endcase
    end

    // Lock FSM state and symbol counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
        end
    end

    // Pick the oldest pending trigger inside the response window; higher
    // index is older, so the last hit in the ascending scan wins.
    always_comb begin
        code_lk = (state == ST_LOCKED) && (is_pcoin || is_ncoin);
        clr_vec = '0;
        hit     = 1'b0;
        for (int i = RESP_LAT - WIN; i < PEND_W; i++) begin
            if (pend[i]) begin
                clr_vec    = '0;
                clr_vec[i] = 1'b1;
                hit        = 1'b1;
            end
        end
        if (!code_lk) begin
            clr_vec = '0;
            hit     = 1'b0;
        end
        pend_aged = pend & ~clr_vec;
        expire    = pend_aged[PEND_W-1] & ~unlock_clr;
        trig_ok   = bus.trig && (state == ST_LOCKED) && (holdoff_cnt == '0);
        tx_nxt    = '0;
        if (trig_ok) begin
            tx_nxt[TX_SINGLE_BIT]       = 1'b1;
            tx_nxt[TX_SINGLE_BIT-1:0]   = bus.trig_toff;
        end
    end

    // Input capture, trigger transmit, pending aging and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q        <= '0;
            pend        <= '0;
            holdoff_cnt <= '0;
            tx_r        <= '0;
            accept_r    <= 1'b0;
            reject_r    <= 1'b0;
            timeout_r   <= 1'b0;
            orphan_r    <= 1'b0;
            drop_r      <= 1'b0;
            code_err_r  <= 1'b0;
            err_cnt_r   <= '0;
        end else begin
            rx_q        <= bus.rx_in;
            pend        <= unlock_clr ? '0 : {pend_aged[PEND_W-2:0], trig_ok};
            if (trig_ok)
                holdoff_cnt <= HO_W'(HOLDOFF);
            else if (holdoff_cnt != '0)
                holdoff_cnt <= holdoff_cnt - HO_W'(1);
            tx_r        <= tx_nxt;
            accept_r    <= code_lk & hit & is_pcoin;
            reject_r    <= code_lk & hit & is_ncoin;
            orphan_r    <= code_lk & ~hit;
            timeout_r   <= expire;
            drop_r      <= bus.trig & ~trig_ok;
            code_err_r  <= code_err_nxt;
            if (code_err_nxt && (err_cnt_r != 16'hFFFF))
                err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    assign bus.locked   = (state == ST_LOCKED);
    assign bus.tx_out   = tx_r;
    assign bus.accept   = accept_r;
    assign bus.reject   = reject_r;
    assign bus.timeout  = timeout_r;
    assign bus.orphan   = orphan_r;
    assign bus.drop     = drop_r;
    assign bus.code_err = code_err_r;
    assign bus.err_cnt  = err_cnt_r;

endmodule
